// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man move/eat datapath and the downstream win-check stage.
package pacman_pkg;

  typedef enum logic [3:0] {
    TILE_EMPTY = 4'd0,
    TILE_WALL  = 4'd1,
    TILE_FOOD  = 4'd2,
    TILE_POWER = 4'd3
  } tile_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EVAL = 2'd2,
    CLR  = 2'd3
  } move_state_t;

  // Codes 4-15 are passable decorations that are never eaten.
  function automatic logic tile_edible(input logic [3:0] code);
    return (code == TILE_FOOD) || (code == TILE_POWER);
  endfunction

endpackage

// File: rtl/pacman_move_eat_if.sv
// Move request handshake plus the single-port tile RAM bus of pacman_move_eat.
interface pacman_move_eat_if #(
  parameter int ADDR_W = 6
);
  // A move transfers on a clock edge where move_valid & move_ready; requests
  // presented while move_ready is low are dropped, never queued.
  logic              move_valid;
  logic [1:0]        move_dir;
  logic              move_ready;
  logic              move_done;
  logic              blocked;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [3:0]        mem_wr_data;
  logic [3:0]        mem_rd_data;

  modport master (
    output move_valid, move_dir, mem_rd_data,
    input  move_ready, move_done, blocked, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  move_valid, move_dir, mem_rd_data,
    output move_ready, move_done, blocked, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/pacman_next_cell.sv
// Combinational target-cell calculator with edge detection.
// PACMAN_TUNNEL_WRAP_EN makes horizontal moves wrap across the row instead of blocking.
module pacman_next_cell
  import pacman_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  dir_t          dir,
  output logic [XW-1:0] tx,
  output logic [YW-1:0] ty,
  output logic          off_grid
);

  always_comb begin
    tx       = x;
    ty       = y;
    off_grid = 1'b0;
    case (dir)
      DIR_UP: begin
        if (y == '0) off_grid = 1'b1;
        else         ty = y - 1'b1;
      end
      DIR_DOWN: begin
        if (y == YW'(GRID_H - 1)) off_grid = 1'b1;
        else                      ty = y + 1'b1;
      end
      DIR_RIGHT: begin
        if (x == XW'(GRID_W - 1)) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          tx = '0;
`else
          off_grid = 1'b1;
`endif
        end else begin
          tx = x + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (x == '0) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          tx = XW'(GRID_W - 1);
`else
          off_grid = 1'b1;
`endif
        end else begin
          tx = x - 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/pacman_move_eat.sv
// Executes one Pac-Man move against the tile RAM: read target, reject walls/edges, eat pellets.
// Horizontal tunnel wrap is enabled by defining PACMAN_TUNNEL_WRAP_EN.
module pacman_move_eat
  import pacman_pkg::*;
#(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  localparam int ADDR_W = $clog2(GRID_W * GRID_H),
  localparam int XW     = $clog2(GRID_W),
  localparam int YW     = $clog2(GRID_H)
) (
  input  logic                clk,
  input  logic                reset,
  pacman_move_eat_if.slave    bus,
  output logic [XW-1:0]       pac_x,
  output logic [YW-1:0]       pac_y,
  output logic [3:0]          tile_out,
  output move_state_t         state_dbg
);

  move_state_t       state, nxt;
  logic [XW-1:0]     tgt_x, nc_x;
  logic [YW-1:0]     tgt_y, nc_y;
  logic              nc_off;
  logic [3:0]        code_q;
  logic              blocked_q;
  logic [ADDR_W-1:0] addr_q;
  logic              accept, eval_wall, eval_pass, eval_eat;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [XW-1:0] cx,
                                                   input logic [YW-1:0] cy);
    return ADDR_W'(cy) * ADDR_W'(GRID_W) + ADDR_W'(cx);
  endfunction

  pacman_next_cell #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_cell (
    .x        (pac_x),
    .y        (pac_y),
    .dir      (dir_t'(bus.move_dir)),
    .tx       (nc_x),
    .ty       (nc_y),
    .off_grid (nc_off)
  );

  assign accept    = bus.move_valid && (state == IDLE);
  assign eval_wall = (state == EVAL) && (bus.mem_rd_data == TILE_WALL);
  assign eval_eat  = (state == EVAL) && tile_edible(bus.mem_rd_data);
  assign eval_pass = (state == EVAL) && !eval_wall && !eval_eat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pac_x     <= XW'(START_X);
      pac_y     <= YW'(START_Y);
      tgt_x     <= '0;
      tgt_y     <= '0;
      code_q    <= '0;
      blocked_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state     <= nxt;
      // Off-grid rejection never touches the RAM, so it is reported one cycle after accept.
      blocked_q <= accept && nc_off;
      if (accept) begin
        tgt_x <= nc_x;
        tgt_y <= nc_y;
        if (!nc_off) addr_q <= cell_addr(nc_x, nc_y);
      end
      if (state == EVAL) code_q <= bus.mem_rd_data;
      if (eval_pass || state == CLR) begin
        pac_x <= tgt_x;
        pac_y <= tgt_y;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept && !nc_off) nxt = RD;
      RD:   nxt = EVAL;
      EVAL: nxt = eval_eat ? CLR : IDLE;
      CLR:  nxt = IDLE;
    endcase
  end

  // Pulses are gated by reset so an abandoned move cannot write or count a pellet.
  assign bus.move_ready  = (state == IDLE);
  assign bus.blocked     = !reset && (blocked_q || eval_wall);
  assign bus.move_done   = !reset && (eval_pass || state == CLR);
  assign bus.mem_wr_en   = !reset && (state == CLR);
  assign bus.mem_wr_data = TILE_EMPTY;
  assign bus.mem_addr    = addr_q;
  assign tile_out        = (!reset && state == CLR) ? code_q : 4'd0;
  assign state_dbg       = state;

endmodule

// File: tb/tb_pacman_move_eat.sv
// Scoreboard bench for pacman_move_eat on an 8x8 maze starting at (1,1).
module tb_pacman_move_eat;
  import pacman_pkg::*;

  localparam int W = 10;  // {latency[2:0], move_done, blocked, tile_out[3:0], mem_wr_en}

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pacman_move_eat_if #(.ADDR_W(6)) bus ();
  logic [2:0]  pac_x, pac_y;
  logic [3:0]  tile_out;
  move_state_t state_dbg;

  pacman_move_eat #(.GRID_W(8), .GRID_H(8), .START_X(1), .START_Y(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .pac_x     (pac_x),
    .pac_y     (pac_y),
    .tile_out  (tile_out),
    .state_dbg (state_dbg)
  );

  // Tile RAM model: synchronous 1-cycle read, with a bench preload port.
  logic [3:0] ram [64];
  logic       pre_we;
  logic [5:0] pre_addr;
  logic [3:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= ram[bus.mem_addr];
  end

  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cnt = 0, last_acc = 0, ev_cnt = 0, wr_cnt = 0, tile_cnt = 0, anom = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expected response whenever the DUT reports a move outcome.
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    if (reset) begin
      if (bus.mem_wr_en || tile_out != 0 || bus.move_done || bus.blocked) anom++;
    end else begin
      if (bus.mem_wr_en) begin
        wr_cnt++;
        if (bus.mem_wr_data != 4'd0) anom++;
      end
      if (tile_out != 4'd0) begin
        tile_cnt++;
        if (!bus.mem_wr_en) anom++;
      end
      if (bus.move_done || bus.blocked) begin
        ev_cnt++;
        act = {3'(cyc - last_acc), bus.move_done, bus.blocked, tile_out, bus.mem_wr_en};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_unexpected got %h required none", act);
        end else begin
          exp_v = exp_q.pop_front();
          if (act !== exp_v) begin
            n_fail++;
            $display("FAIL event_outcome got lat=%0d done=%0b blk=%0b tile=%0d wr=%0b required lat=%0d done=%0b blk=%0b tile=%0d wr=%0b",
                     act[9:7], act[6], act[5], act[4:1], act[0],
                     exp_v[9:7], exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
          end
        end
      end
      if (bus.move_valid && bus.move_ready) begin
        acc_cnt++;
        last_acc = cyc;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input int d);
    pre_addr = 6'(a);
    pre_data = 4'(d);
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic push_exp(input int lat, input bit done, input bit blk, input int tile);
    exp_q.push_back({3'(lat), done, blk, 4'(tile), (tile != 0)});
  endtask

  task automatic wait_idle(input string name, input int ev_target);
    int n = 0;
    while (ev_cnt < ev_target && n < 30) begin
      tick();
      n++;
    end
    chk({name, "_events"}, ev_cnt, ev_target);
    n = 0;
    while (!bus.move_ready && n < 10) begin
      tick();
      n++;
    end
  endtask

  // exp_addr < 0 means the move is rejected at the edge without any RAM read.
  task automatic do_move(input string name, input int dir, input int lat, input bit done,
                         input bit blk, input int tile, input int exp_addr,
                         input int ex, input int ey);
    int ev0   = ev_cnt;
    int acc0  = acc_cnt;
    int addr0 = int'(bus.mem_addr);
    push_exp(lat, done, blk, tile);
    bus.move_dir   = 2'(dir);
    bus.move_valid = 1'b1;
    tick();
    bus.move_valid = 1'b0;
    chk({name, "_accept"}, acc_cnt, acc0 + 1);
    if (exp_addr >= 0) begin
      chk({name, "_rd_addr"}, int'(bus.mem_addr), exp_addr);
    end else begin
      chk({name, "_stay_idle"}, int'(bus.move_ready), 1);
      chk({name, "_no_read"}, int'(bus.mem_addr), addr0);
    end
    wait_idle(name, ev0 + 1);
    chk({name, "_pac_x"}, int'(pac_x), ex);
    chk({name, "_pac_y"}, int'(pac_y), ey);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ev0, acc0, wr0, tile0;
    reset          = 1'b1;
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    pre_we         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;
    for (int i = 0; i < 64; i++) poke(i, 0);
    tick();
    reset = 1'b0;

    // Idle after reset
    repeat (5) tick();
    chk("reset_pac_x", int'(pac_x), 1);
    chk("reset_pac_y", int'(pac_y), 1);
    chk("reset_ready", int'(bus.move_ready), 1);
    chk("reset_state", int'(state_dbg), int'(IDLE));
    chk("reset_events", ev_cnt, 0);
    chk("reset_writes", wr_cnt, 0);
    chk("reset_anomalies", anom, 0);

    // Food to the right: read at T+1, write/tile/done at T+3, position at T+4
    poke(10, 2);
    do_move("food_right", 1, 3, 1'b1, 1'b0, 2, 10, 2, 1);
    chk("food_right_ram", int'(ram[10]), 0);
    chk("food_right_writes", wr_cnt, 1);
    chk("food_right_tiles", tile_cnt, 1);

    // Empty move back, then wall at (0,1)
    do_move("empty_left", 3, 2, 1'b1, 1'b0, 0, 9, 1, 1);
    poke(8, 1);
    do_move("wall_left", 3, 2, 1'b0, 1'b1, 0, 8, 1, 1);
    chk("wall_ram", int'(ram[8]), 1);
    chk("wall_writes", wr_cnt, 1);

    // Walk to (0,3), then test the left edge
    do_move("down_1", 2, 2, 1'b1, 1'b0, 0, 17, 1, 2);
    do_move("down_2", 2, 2, 1'b1, 1'b0, 0, 25, 1, 3);
    do_move("to_edge", 3, 2, 1'b1, 1'b0, 0, 24, 0, 3);
`ifdef PACMAN_TUNNEL_WRAP_EN
    do_move("tunnel_left", 3, 2, 1'b1, 1'b0, 0, 31, 7, 3);
    do_move("tunnel_right", 1, 2, 1'b1, 1'b0, 0, 24, 0, 3);
`else
    do_move("edge_left", 3, 1, 1'b0, 1'b1, 0, -1, 0, 3);
`endif

    // move_valid held high across two pellet moves: one accept per IDLE visit
    poke(25, 2);
    poke(26, 3);
    ev0  = ev_cnt;
    acc0 = acc_cnt;
    push_exp(3, 1'b1, 1'b0, 2);
    push_exp(3, 1'b1, 1'b0, 3);
    bus.move_dir   = 2'd1;
    bus.move_valid = 1'b1;
    repeat (8) tick();
    bus.move_valid = 1'b0;
    wait_idle("hold_valid", ev0 + 2);
    chk("hold_valid_accepts", acc_cnt, acc0 + 2);
    chk("hold_valid_pac_x", int'(pac_x), 2);
    chk("hold_valid_pac_y", int'(pac_y), 3);
    chk("hold_valid_ram25", int'(ram[25]), 0);
    chk("hold_valid_ram26", int'(ram[26]), 0);
    chk("hold_valid_writes", wr_cnt, 3);
    chk("hold_valid_tiles", tile_cnt, 3);

    // Reset during EVAL of a food move abandons it
    poke(27, 2);
    ev0   = ev_cnt;
    acc0  = acc_cnt;
    wr0   = wr_cnt;
    tile0 = tile_cnt;
    bus.move_dir   = 2'd1;
    bus.move_valid = 1'b1;
    tick();
    bus.move_valid = 1'b0;
    tick();
    chk("abort_in_eval", int'(state_dbg), int'(EVAL));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("abort_accepts", acc_cnt, acc0 + 1);
    chk("abort_events", ev_cnt, ev0);
    chk("abort_writes", wr_cnt, wr0);
    chk("abort_tiles", tile_cnt, tile0);
    chk("abort_pac_x", int'(pac_x), 1);
    chk("abort_pac_y", int'(pac_y), 1);
    chk("abort_ram27", int'(ram[27]), 2);
    chk("abort_queue", exp_q.size(), 0);

    // Top edge and a passable non-edible code
    do_move("up_empty", 0, 2, 1'b1, 1'b0, 0, 1, 1, 0);
    do_move("up_edge", 0, 1, 1'b0, 1'b1, 0, -1, 1, 0);
    poke(2, 5);
    do_move("odd_tile", 1, 2, 1'b1, 1'b0, 0, 2, 2, 0);
    chk("odd_tile_ram", int'(ram[2]), 5);

    repeat (3) tick();
    chk("final_anomalies", anom, 0);
    chk("final_queue", exp_q.size(), 0);
    chk("final_writes", wr_cnt, 3);
    chk("final_tiles", tile_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pacman_move_eat.md
Name: pacman_move_eat

Overview:
- Executes one Pac-Man move request at a time against the maze tile RAM, which is single-port with a synchronous 1-cycle read.
- Reads the target cell, rejects walls and edges, advances the position register, and clears eaten pellets by writing TILE_EMPTY back.
- Drives tile_out, a 4-bit tile stream consumed directly by the downstream win-check counter. That counter increments on every cycle tile_out == 2, so each pellet must appear for exactly one cycle.

Parameters:
- GRID_W, 8, maze width in cells.
- GRID_H, 8, maze height in cells.
- START_X, 1, reset column of Pac-Man.
- START_Y, 1, reset row of Pac-Man.
- ADDR_W, $clog2(GRID_W*GRID_H), tile RAM address width (derived; not overridden).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  move request.
- move_dir  in  2  0=up (y-1), 1=right (x+1), 2=down (y+1), 3=left (x-1).
- move_ready  out  1  high only in IDLE.
- mem_addr  out  ADDR_W  tile address = y*GRID_W + x.
- mem_wr_en  out  1  tile write strobe.
- mem_wr_data  out  4  tile write data (always TILE_EMPTY).
- mem_rd_data  in  4  tile read data, valid one cycle after mem_addr.
- pac_x  out  $clog2(GRID_W)  current column.
- pac_y  out  $clog2(GRID_H)  current row.
- move_done  out  1  one-cycle pulse: move accepted and position updated.
- blocked  out  1  one-cycle pulse: move rejected (wall or edge).
- tile_out  out  4  eaten tile code for one cycle, else 0; feeds the win counter.

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-high.
  - Reset returns the FSM to IDLE and sets pac_x=START_X, pac_y=START_Y.
  - Reset clears move_done, blocked, tile_out and mem_wr_en to 0. mem_addr resets to 0.
  - Reset mid-operation abandons the move. No write is issued in or after the reset cycle.
- Tile codes:
  - 0 EMPTY: passable.
  - 1 WALL: blocks.
  - 2 FOOD: passable and cleared.
  - 3 POWER: passable and cleared.
  - 4-15: passable, not cleared, tile_out stays 0.
- FSM (IDLE, RD, EVAL, CLR), handshake accepted at cycle T when move_valid & move_ready:
  - IDLE: compute target cell with pacman_next_cell and latch it.
    - If the target is off-grid: blocked=1 at T+1, FSM stays IDLE, no RAM read.
    - Otherwise go to RD.
  - RD (T+1): mem_addr = target address.
  - EVAL (T+2): decode mem_rd_data.
    - WALL: blocked=1 at T+2, go to IDLE.
    - EMPTY or 4-15: position updated (visible T+3), move_done=1 at T+2, go to IDLE.
    - FOOD or POWER: go to CLR.
  - CLR (T+3):
    - mem_wr_en=1, mem_addr=target, mem_wr_data=0.
    - tile_out = read code (2 or 3) for this cycle only.
    - move_done=1; position updated (visible T+4); go to IDLE.
- Handshake rules:
  - move_valid outside IDLE is ignored and not queued.
  - move_valid in the cycle a move completes is not accepted until the next IDLE cycle.
- Outputs in FSM cycles:
  - move_done and blocked are never high together.
  - tile_out is 0 in every cycle except CLR.
  - mem_wr_en is high only in CLR.
- Arithmetic: coordinates are unsigned. Edge checks are x==0 for left, x==GRID_W-1 for right, and likewise y against 0 and GRID_H-1. No underflow wrap is permitted.

Optional Feature:
- PACMAN_TUNNEL_WRAP_EN defined:
  - Left from x=0 targets x=GRID_W-1; right from x=GRID_W-1 targets x=0, same row. The wrapped cell is read and judged normally.
  - Vertical edges still block.
- Undefined: all four edges block as described above.

Decomposition:
- pacman_pkg contains:
  - tile_t: 4-bit enum TILE_EMPTY=0, TILE_WALL=1, TILE_FOOD=2, TILE_POWER=3.
  - dir_t: DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT.
  - move_state_t: IDLE, RD, EVAL, CLR.
  - The win-check stage reuses tile_t.
- One combinational sub-module, pacman_next_cell:
  - Inputs: x, y, dir.
  - Outputs: target x, target y, off_grid.
  - The tunnel macro is honoured inside it.

Test Plan (GRID 8x8, start (1,1)):
- Reset, then idle 5 cycles -> pac=(1,1), move_ready=1, all pulses and tile_out 0, no mem_wr_en.
- RAM[1*8+2]=2, move right at T -> mem_addr=10 at T+1; at T+3 mem_wr_en=1, addr 10, data 0, tile_out=2 for one cycle, move_done=1; pac=(2,1) at T+4; RAM[10]=0.
- RAM[1*8+0]=1, move left -> blocked=1 at T+2, pac stays (1,1), no write, tile_out 0.
- Pac at (0,3), move left, macro off -> blocked=1 at T+1, no read. Macro on with RAM[31]=0 -> mem_addr=31, pac=(7,3), move_done at T+2.
- Assert move_valid continuously during food move -> exactly one acceptance per IDLE visit, tile_out=2 exactly once per pellet cell.
- Reset asserted at EVAL of food move -> no write, tile_out 0, pac=(1,1), RAM cell still 2.
